ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 32-bit MIPS core; sits directly downstream of the 32-bit ALU and captures its result F, its Z/OV/CO flags and the EX-stage control bits.
- Resolves BEQ/BNE from the ALU zero flag.
- Detects signed-overflow traps (ADD/SUB/ADDI) and suppresses their side effects.
- Holds a sticky exception record (EPC) until the exception logic acknowledges it.

Parameters:
DATA_W, 32, datapath/PC width
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all stage registers
flush  in  1  squash the stage (bubble)
in_valid  in  1  EX holds a real instruction
alu_f  in  DATA_W  ALU result
alu_z  in  1  ALU zero flag
alu_ov  in  1  ALU signed overflow
alu_co  in  1  ALU carry out
ov_trap_en  in  1  instruction traps on overflow (ADD/SUB/ADDI; 0 for ADDU/SUBU)
rt_data  in  DATA_W  store data
pc  in  DATA_W  PC of EX instruction
br_target  in  DATA_W  computed branch target
dest_reg  in  REG_ADDR_W  writeback register
reg_write, mem_read, mem_write, branch_eq, branch_ne  in  1 each  EX control bits
exc_ack  in  1  exception logic consumed the record
m_valid  out  1  MEM holds a real instruction
m_alu_result  out  DATA_W  registered alu_f
m_store_data  out  DATA_W  registered rt_data
m_dest_reg  out  REG_ADDR_W  registered dest_reg
m_reg_write, m_mem_read, m_mem_write  out  1 each  registered, qualified controls
br_taken  out  1  registered branch decision
br_pc  out  DATA_W  registered br_target
exc_pending  out  1  sticky overflow exception
epc  out  DATA_W  PC of trapping instruction

Behaviour:
- Reset (async, rst_n=0): every output and internal register = 0, immediately; no clock needed.
- Latency: 1 cycle from EX inputs to m_* / br_* outputs.
- Priority per edge: flush > stall > capture.
- flush=1: m_valid, m_reg_write, m_mem_read, m_mem_write and br_taken -> 0. Data registers (m_alu_result, m_store_data, m_dest_reg, br_pc) are don't-care; implementation holds them. flush overrides stall.
- stall=1 and flush=0: all stage registers hold their values.
- Capture (no flush, no stall): all fields load from inputs; m_valid <= in_valid.
- Qualification: when in_valid=0, m_reg_write, m_mem_read, m_mem_write and br_taken load 0.
- br_taken <= in_valid & ((branch_eq & alu_z) | (branch_ne & ~alu_z)).
- Trap condition T = capture & in_valid & ov_trap_en & alu_ov.
- On T: m_reg_write <= 0 and m_mem_write <= 0. m_valid still loads 1, m_alu_result still loads alu_f.
- Exception record:
  - On T with exc_pending=0: exc_pending <= 1, epc <= pc.
  - On T with exc_pending=1 and no exc_ack: first exception wins; epc holds.
  - exc_ack=1 and no T: exc_pending <= 0; epc holds.
  - exc_ack=1 and T on the same edge: new record wins; exc_pending stays 1, epc <= new pc.
- alu_co is consumed only under the optional feature below; it does not affect the other outputs.
- Stall/flush never clear exc_pending; only exc_ack or reset clears it.

Optional Feature:
- Macro EX_MEM_FLAGS_EN.
- Defined: adds outputs m_z, m_ov, m_co (1 bit each). They are registered alu_z/alu_ov/alu_co with the same reset/flush/stall/capture rules as the data fields, and reset to 0.
- Undefined: these ports and their flops do not exist; alu_co is unused. All other behaviour is identical.

Test Plan:
- Reset mid-operation: load a valid instruction, then pull rst_n low between edges -> all outputs 0 immediately, before the next edge.
- Capture: in_valid=1, alu_f=32'h0000_1234, reg_write=1, dest_reg=5'd9 -> next cycle m_valid=1, m_alu_result=32'h0000_1234, m_reg_write=1, m_dest_reg=9.
- Stall then flush: capture 32'hDEAD_BEEF, hold stall=1 for 3 cycles with changing inputs -> output unchanged for 3 cycles. Then flush=1 together with stall=1 -> m_valid=0, m_reg_write=0.
- Branch: branch_eq=1, alu_z=1, br_target=32'h0040_0100 -> br_taken=1, br_pc=32'h0040_0100. branch_ne=1, alu_z=1 -> br_taken=0.
- Overflow trap:
  - ov_trap_en=1, alu_ov=1, pc=32'h0040_0020, reg_write=1 -> m_reg_write=0, exc_pending=1, epc=32'h0040_0020.
  - Second trap at pc=32'h0040_0030 without ack -> epc unchanged.
  - ov_trap_en=0 with alu_ov=1 -> no exception, m_reg_write=1.
- Ack collision: exc_ack=1 and a trap at pc=32'h0040_0040 on the same edge -> exc_pending=1, epc=32'h0040_0040. Lone ack on the following edge -> exc_pending=0.

Source files
------------

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with branch resolve, overflow trap and sticky EPC; EX_MEM_FLAGS_EN adds registered ALU flags
module ex_mem_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     alu_f,
  input  logic                  alu_z,
  input  logic                  alu_ov,
  input  logic                  alu_co,
  input  logic                  ov_trap_en,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic [DATA_W-1:0]     pc,
  input  logic [DATA_W-1:0]     br_target,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic                  exc_ack,
  output logic                  m_valid,
  output logic [DATA_W-1:0]     m_alu_result,
  output logic [DATA_W-1:0]     m_store_data,
  output logic [REG_ADDR_W-1:0] m_dest_reg,
  output logic                  m_reg_write,
  output logic                  m_mem_read,
  output logic                  m_mem_write,
  output logic                  br_taken,
  output logic [DATA_W-1:0]     br_pc,
  output logic                  exc_pending,
`ifdef EX_MEM_FLAGS_EN
  output logic                  m_z,
  output logic                  m_ov,
  output logic                  m_co,
`endif
  output logic [DATA_W-1:0]     epc
);
  logic capture, trap;
  logic valid_q, valid_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, bt_q, bt_d, pend_q, pend_d;
  logic [DATA_W-1:0] alu_q, alu_d, sd_q, sd_d, bpc_q, bpc_d, epc_q, epc_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  always_comb begin
    capture = ~flush & ~stall;
    trap    = capture & in_valid & ov_trap_en & alu_ov;
    valid_d = flush ? 1'b0 : stall ? valid_q : in_valid;
    rw_d    = flush ? 1'b0 : stall ? rw_q : in_valid & reg_write & ~trap;
    mr_d    = flush ? 1'b0 : stall ? mr_q : in_valid & mem_read;
    mw_d    = flush ? 1'b0 : stall ? mw_q : in_valid & mem_write & ~trap;
    bt_d    = flush ? 1'b0 : stall ? bt_q : in_valid & ((branch_eq & alu_z) | (branch_ne & ~alu_z));
    alu_d   = capture ? alu_f : alu_q;
    sd_d    = capture ? rt_data : sd_q;
    dest_d  = capture ? dest_reg : dest_q;
    bpc_d   = capture ? br_target : bpc_q;
    pend_d  = trap ? 1'b1 : exc_ack ? 1'b0 : pend_q;
    epc_d   = trap & (~pend_q | exc_ack) ? pc : epc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      bt_q    <= 1'b0;
      alu_q   <= '0;
      sd_q    <= '0;
      dest_q  <= '0;
      bpc_q   <= '0;
      pend_q  <= 1'b0;
      epc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      bt_q    <= bt_d;
      alu_q   <= alu_d;
      sd_q    <= sd_d;
      dest_q  <= dest_d;
      bpc_q   <= bpc_d;
      pend_q  <= pend_d;
      epc_q   <= epc_d;
    end
  end
  assign m_valid      = valid_q;
  assign m_alu_result = alu_q;
  assign m_store_data = sd_q;
  assign m_dest_reg   = dest_q;
  assign m_reg_write  = rw_q;
  assign m_mem_read   = mr_q;
  assign m_mem_write  = mw_q;
  assign br_taken     = bt_q;
  assign br_pc        = bpc_q;
  assign exc_pending  = pend_q;
  assign epc          = epc_q;
`ifdef EX_MEM_FLAGS_EN
  logic [2:0] flg_q, flg_d;
  always_comb flg_d = capture ? {alu_z, alu_ov, alu_co} : flg_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flg_q <= '0;
    else flg_q <= flg_d;
  end
  assign {m_z, m_ov, m_co} = flg_q;
`else
  logic unused_co;
  assign unused_co = alu_co;
`endif
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed scoreboard bench for ex_mem_reg
module tb_ex_mem_reg;
  logic clk = 1'b0, rst_n;
  logic stall, flush, in_valid, alu_z, alu_ov, alu_co, ov_trap_en;
  logic [31:0] alu_f, rt_data, pc, br_target;
  logic [4:0] dest_reg;
  logic reg_write, mem_read, mem_write, branch_eq, branch_ne, exc_ack;
  logic m_valid, m_reg_write, m_mem_read, m_mem_write, br_taken, exc_pending;
  logic [31:0] m_alu_result, m_store_data, br_pc, epc;
  logic [4:0] m_dest_reg;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic v; logic [31:0] alu, sd; logic [4:0] dest;
    logic rw, mr, mw, bt; logic [31:0] bpc; logic pend; logic [31:0] epc; bit dc;
  } exp_t;
  exp_t sb[$];
  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_f(alu_f), .alu_z(alu_z), .alu_ov(alu_ov), .alu_co(alu_co), .ov_trap_en(ov_trap_en),
    .rt_data(rt_data), .pc(pc), .br_target(br_target), .dest_reg(dest_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .exc_ack(exc_ack),
    .m_valid(m_valid), .m_alu_result(m_alu_result), .m_store_data(m_store_data),
    .m_dest_reg(m_dest_reg), .m_reg_write(m_reg_write), .m_mem_read(m_mem_read),
    .m_mem_write(m_mem_write), .br_taken(br_taken), .br_pc(br_pc),
    .exc_pending(exc_pending), .epc(epc)
  );
  always #5 clk = ~clk;
  task automatic clr();
    {stall, flush, in_valid, alu_z, alu_ov, alu_co, ov_trap_en} = '0;
    {alu_f, rt_data, pc, br_target, dest_reg} = '0;
    {reg_write, mem_read, mem_write, branch_eq, branch_ne, exc_ack} = '0;
  endtask
  task automatic push(input logic v, input logic [31:0] alu, sd, input logic [4:0] dest,
                      input logic rw, mr, mw, bt, input logic [31:0] bpc,
                      input logic pend, input logic [31:0] e, input bit dc);
    sb.push_back('{v, alu, sd, dest, rw, mr, mw, bt, bpc, pend, e, dc});
  endtask
  task automatic chk(input string tag, input string f, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s.%s: got %h want %h", tag, f, got, want);
    end
  endtask
  task automatic cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk(tag, "m_valid", {31'b0, m_valid}, {31'b0, e.v});
    chk(tag, "m_reg_write", {31'b0, m_reg_write}, {31'b0, e.rw});
    chk(tag, "m_mem_read", {31'b0, m_mem_read}, {31'b0, e.mr});
    chk(tag, "m_mem_write", {31'b0, m_mem_write}, {31'b0, e.mw});
    chk(tag, "br_taken", {31'b0, br_taken}, {31'b0, e.bt});
    chk(tag, "exc_pending", {31'b0, exc_pending}, {31'b0, e.pend});
    chk(tag, "epc", epc, e.epc);
    if (!e.dc) begin
      chk(tag, "m_alu_result", m_alu_result, e.alu);
      chk(tag, "m_store_data", m_store_data, e.sd);
      chk(tag, "m_dest_reg", {27'b0, m_dest_reg}, {27'b0, e.dest});
      chk(tag, "br_pc", br_pc, e.bpc);
    end
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    cmp(tag);
  endtask
  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("reset");
    #10 rst_n = 1'b1;
    clr(); in_valid = 1; alu_f = 32'h0000_1234; reg_write = 1; dest_reg = 9; rt_data = 32'h55;
    push(1, 32'h0000_1234, 32'h55, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    tick("capture");
    clr(); in_valid = 1; alu_f = 32'hDEAD_BEEF; rt_data = 32'hCAFE_0001; dest_reg = 3; reg_write = 1;
    push(1, 32'hDEAD_BEEF, 32'hCAFE_0001, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    tick("capture2");
    for (int i = 0; i < 3; i++) begin
      clr(); stall = 1; in_valid = 1; alu_f = $urandom; rt_data = $urandom; dest_reg = 5'(20 + i);
      mem_write = 1; mem_read = 1; branch_eq = 1; alu_z = 1; br_target = $urandom;
      push(1, 32'hDEAD_BEEF, 32'hCAFE_0001, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      tick("stall");
    end
    clr(); stall = 1; flush = 1; in_valid = 1; reg_write = 1;
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("flush_over_stall");
    clr(); in_valid = 1; branch_eq = 1; alu_z = 1; br_target = 32'h0040_0100;
    push(1, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0100, 0, 0, 0);
    tick("beq_taken");
    clr(); in_valid = 1; branch_ne = 1; alu_z = 1; alu_f = 1; br_target = 32'h0040_0200;
    push(1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0200, 0, 0, 0);
    tick("bne_not_taken");
    clr(); in_valid = 1; branch_ne = 1; alu_z = 0; alu_f = 5; br_target = 32'h0040_0300;
    push(1, 5, 0, 0, 0, 0, 0, 1, 32'h0040_0300, 0, 0, 0);
    tick("bne_taken");
    clr(); branch_eq = 1; alu_z = 1; reg_write = 1; mem_read = 1; mem_write = 1;
    alu_f = 32'hAA; br_target = 32'h0040_0400; dest_reg = 7;
    push(0, 32'hAA, 0, 7, 0, 0, 0, 0, 32'h0040_0400, 0, 0, 0);
    tick("invalid_qualify");
    clr(); in_valid = 1; mem_read = 1; alu_f = 32'h1000; dest_reg = 8; reg_write = 1;
    push(1, 32'h1000, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    tick("load");
    clr(); in_valid = 1; ov_trap_en = 1; alu_ov = 1; pc = 32'h0040_0020; reg_write = 1;
    mem_write = 1; alu_f = 32'h8000_0000; rt_data = 32'h11; dest_reg = 10;
    push(1, 32'h8000_0000, 32'h11, 10, 0, 0, 0, 0, 0, 1, 32'h0040_0020, 0);
    tick("trap1");
    clr(); in_valid = 1; ov_trap_en = 1; alu_ov = 1; pc = 32'h0040_0030; reg_write = 1;
    mem_write = 1; alu_f = 32'h8000_0001; rt_data = 32'h11; dest_reg = 10;
    push(1, 32'h8000_0001, 32'h11, 10, 0, 0, 0, 0, 0, 1, 32'h0040_0020, 0);
    tick("trap2_first_wins");
    clr(); in_valid = 1; alu_ov = 1; pc = 32'h0040_0034; reg_write = 1; dest_reg = 11; alu_f = 7;
    push(1, 7, 0, 11, 1, 0, 0, 0, 0, 1, 32'h0040_0020, 0);
    tick("ov_no_trap");
    clr(); stall = 1; in_valid = 1; ov_trap_en = 1; alu_ov = 1; pc = 32'h0040_0050; reg_write = 1;
    push(1, 7, 0, 11, 1, 0, 0, 0, 0, 1, 32'h0040_0020, 0);
    tick("stalled_trap");
    clr(); flush = 1; in_valid = 1; reg_write = 1;
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0020, 1);
    tick("flush_keeps_exc");
    clr(); exc_ack = 1; in_valid = 1; ov_trap_en = 1; alu_ov = 1; pc = 32'h0040_0040;
    alu_f = 3; dest_reg = 12; reg_write = 1;
    push(1, 3, 0, 12, 0, 0, 0, 0, 0, 1, 32'h0040_0040, 0);
    tick("ack_collision");
    clr(); exc_ack = 1; in_valid = 1; alu_f = 4; dest_reg = 13; reg_write = 1; pc = 32'h0040_0044;
    push(1, 4, 0, 13, 1, 0, 0, 0, 0, 0, 32'h0040_0040, 0);
    tick("lone_ack");
    clr(); in_valid = 1; alu_f = 32'h99; dest_reg = 2; rt_data = 32'h77; branch_eq = 1; alu_z = 1;
    br_target = 32'h0040_0500; ov_trap_en = 1; alu_ov = 1; pc = 32'h0040_0060;
    push(1, 32'h99, 32'h77, 2, 0, 0, 0, 1, 32'h0040_0500, 1, 32'h0040_0060, 0);
    tick("pre_reset");
    clr();
    rst_n = 1'b0;
    #1;
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("reset_mid");
    #10 rst_n = 1'b1;
    #10;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
